// File: rtl/uart_pkg.sv
// Shared types and helpers for the UART receive path.
package uart_pkg;

    // Parity modes, numbered to match the PARITY parameter of the receiver.
    typedef enum logic [1:0] {
        NONE = 2'd0,
        ODD  = 2'd1,
        EVEN = 2'd2
    } parity_t;

    // Receiver frame states.
    typedef enum logic [2:0] {
        StIdle      = 3'd0,
        StStart     = 3'd1,
        StData      = 3'd2,
        StParity    = 3'd3,
        StStop      = 3'd4,
        StBreakWait = 3'd5
    } rx_state_t;

    // Two-out-of-three vote used to decide each bit from its three samples.
    function automatic logic majority3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// Two-flop synchroniser for an asynchronous single-bit input.
// The reset value is a parameter so idle-high and idle-low lines can share it.
module uart_rx_sync #(
    parameter logic RESET_VAL = 1'b1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic meta;

    // Capture the raw input, then retime it once more before anyone uses it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta <= RESET_VAL;
            q    <= RESET_VAL;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/uart_rx_param.sv
// Parametrised UART receiver: 5..9 data bits, optional odd/even parity,
// 1 or 2 stop bits, 3-sample majority voting per bit, and parity / framing /
// break reporting with a single-cycle data-valid strobe per frame.
module uart_rx_param
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 10416,
    parameter int DATA_BITS    = 8,
    parameter int PARITY       = 0,
    parameter int STOP_BITS    = 1
) (
    input  logic                 i_Clock,
    input  logic                 i_Reset_n,
    input  logic                 i_RX_Serial,
    output logic                 o_RX_DV,
    output logic [DATA_BITS-1:0] o_RX_Byte,
    output logic                 o_Parity_Err,
    output logic                 o_Frame_Err,
    output logic                 o_Break
);

    // ------------------------------------------------------------------
    // Elaboration-time parameter legality
    // ------------------------------------------------------------------
    if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_chk_data_bits
        $error("uart_rx_param: DATA_BITS must be in 5..9");
    end
    if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_chk_stop_bits
        $error("uart_rx_param: STOP_BITS must be 1 or 2");
    end
    if (CLKS_PER_BIT < 4) begin : g_chk_clks
        $error("uart_rx_param: CLKS_PER_BIT must be 4 or more");
    end
    if (PARITY < 0 || PARITY > 2) begin : g_chk_parity
        $error("uart_rx_param: PARITY must be 0, 1 or 2");
    end

    // ------------------------------------------------------------------
    // Derived constants
    // ------------------------------------------------------------------
    localparam int CntW = $clog2(CLKS_PER_BIT);
    localparam int Mid  = (CLKS_PER_BIT - 1) / 2;
    localparam int IdxW = $clog2(DATA_BITS);

    // Samples straddle the bit centre; the decision uses the third one live.
    localparam logic [CntW-1:0] CntSmp0 = CntW'(Mid - 1);
    localparam logic [CntW-1:0] CntSmp1 = CntW'(Mid);
    localparam logic [CntW-1:0] CntDec  = CntW'(Mid + 1);
    localparam logic [CntW-1:0] CntLast = CntW'(CLKS_PER_BIT - 1);

    localparam logic [IdxW-1:0] IdxLast = IdxW'(DATA_BITS - 1);
    localparam parity_t         ParMode = parity_t'(PARITY[1:0]);

    // ------------------------------------------------------------------
    // Signals
    // ------------------------------------------------------------------
    logic                 rx_s;
    rx_state_t            state;
    logic [CntW-1:0]      cnt;
    logic [IdxW-1:0]      bit_idx;
    logic                 stop_idx;
    logic                 smp0;
    logic                 smp1;
    logic [DATA_BITS-1:0] shreg;
    logic                 par_bit;
    logic                 frame_acc;
    logic                 all_zero;

    logic                 at_dec;
    logic                 bit_val;
    logic                 last_stop;
    logic                 par_err;

    // ------------------------------------------------------------------
    // Input synchroniser (line idles high)
    // ------------------------------------------------------------------
    uart_rx_sync #(
        .RESET_VAL (1'b1)
    ) u_sync (
        .clk   (i_Clock),
        .rst_n (i_Reset_n),
        .d     (i_RX_Serial),
        .q     (rx_s)
    );

    // ------------------------------------------------------------------
    // Bit decision and frame status helpers
    // ------------------------------------------------------------------

    // Decision strobe, voted bit value and end-of-frame / parity evaluation.
    always_comb begin
        at_dec    = (cnt == CntDec);
        bit_val   = majority3(smp0, smp1, rx_s);
        last_stop = (STOP_BITS == 1) || stop_idx;
        par_err   = 1'b0;
        unique case (ParMode)
            ODD:     par_err = ~(^shreg ^ par_bit);
            EVEN:    par_err = ^shreg ^ par_bit;
            default: par_err = 1'b0;
        endcase
    end

    // ------------------------------------------------------------------
    // Receive FSM with bit timer, sampling and registered outputs
    // ------------------------------------------------------------------

    // Frame sequencing: start qualification, data shift, parity, stop and break.
    always_ff @(posedge i_Clock or negedge i_Reset_n) begin
        if (!i_Reset_n) begin
            state        <= StIdle;
            cnt          <= '0;
            bit_idx      <= '0;
            stop_idx     <= 1'b0;
            smp0         <= 1'b1;
            smp1         <= 1'b1;
            shreg        <= '0;
            par_bit      <= 1'b0;
            frame_acc    <= 1'b0;
            all_zero     <= 1'b0;
            o_RX_DV      <= 1'b0;
            o_RX_Byte    <= '0;
            o_Parity_Err <= 1'b0;
            o_Frame_Err  <= 1'b0;
            o_Break      <= 1'b0;
        end else begin
            o_RX_DV <= 1'b0;

            if (cnt == CntSmp0) begin
                smp0 <= rx_s;
            end
            if (cnt == CntSmp1) begin
                smp1 <= rx_s;
            end

            // Bit timer free-runs through a frame; IDLE reloads it on the start edge.
            if (state != StIdle && state != StBreakWait) begin
                cnt <= (cnt == CntLast) ? '0 : cnt + 1'b1;
            end

            case (state)
                StIdle: begin
                    if (!rx_s) begin
                        // The detecting cycle itself counts as cnt 0.
                        cnt       <= CntW'(1);
                        bit_idx   <= '0;
                        stop_idx  <= 1'b0;
                        frame_acc <= 1'b0;
                        all_zero  <= 1'b1;
                        state     <= StStart;
                    end
                end

                StStart: begin
                    if (at_dec) begin
                        state <= bit_val ? StIdle : StData;
                    end
                end

                StData: begin
                    if (at_dec) begin
                        // LSB first: after DATA_BITS shifts bit 0 holds the first bit.
                        shreg    <= {bit_val, shreg[DATA_BITS-1:1]};
                        all_zero <= all_zero & ~bit_val;
                        if (bit_idx == IdxLast) begin
                            state <= (ParMode != NONE) ? StParity : StStop;
                        end else begin
                            bit_idx <= bit_idx + 1'b1;
                        end
                    end
                end

                StParity: begin
                    if (at_dec) begin
                        par_bit  <= bit_val;
                        all_zero <= all_zero & ~bit_val;
                        state    <= StStop;
                    end
                end

                StStop: begin
                    if (at_dec) begin
                        if (last_stop) begin
                            o_RX_DV      <= 1'b1;
                            o_RX_Byte    <= shreg;
                            o_Parity_Err <= par_err;
                            o_Frame_Err  <= frame_acc | ~bit_val;
                            o_Break      <= all_zero & ~bit_val;
                            // Leaving mid-bit lets the next start edge resynchronise.
                            state        <= (all_zero & ~bit_val) ? StBreakWait : StIdle;
                        end else begin
                            stop_idx  <= 1'b1;
                            frame_acc <= frame_acc | ~bit_val;
                            all_zero  <= all_zero & ~bit_val;
                        end
                    end
                end

                StBreakWait: begin
                    // Ignore the held-low line until it recovers to idle.
                    if (rx_s) begin
                        state <= StIdle;
                    end
                end

                default: begin
                    state <= StIdle;
                end
            endcase
        end
    end

endmodule
